// File: rtl/ast_dmx.sv
// ---------------------------------------------------------------------------
// ast_dmx : Avalon-ST 1-to-TX_DIR packet demultiplexer.
//
// A single sink stream is split per packet: the destination chosen by dir_i on
// the startofpacket beat carries the whole packet. Each direction owns one
// output register stage, so a stalled consumer only blocks the sink while the
// current packet is aimed at it; other directions keep draining.
//
// Handshake: a beat moves across an interface on a clock edge where valid and
// ready are both high. valid/payload are held until that edge; ready may be
// high without valid. ast_ready_o is combinational from dir_i/sop, the current
// state and the selected direction's register (valid and ready_i).
//
// Ports
//   clk_i, srst_i             clock, synchronous active-high reset
//   dir_i                     destination select, looked at on the sop beat
//   ast_*_i / ast_ready_o     sink stream
//   ast_*_o[k] / ast_ready_i  source stream for direction k
//   dbg_state_o               packet FSM state (0 = IDLE, 1 = BUSY)
//
// Build option
//   AST_DMX_DROP_BAD_DIR_EN   defined  : a packet whose sop-beat dir_i >= TX_DIR
//                                        is swallowed (ready held high to eop).
//                             undefined: such a packet goes to direction 0.
// ---------------------------------------------------------------------------
module ast_dmx #(
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 8,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = (TX_DIR == 1) ? 1 : $clog2(TX_DIR)
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [DIR_SEL_WIDTH-1:0] dir_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i,
    input  logic                     ast_startofpacket_i,
    input  logic                     ast_endofpacket_i,
    input  logic                     ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i,
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i,
    output logic                     ast_ready_o,
    output logic [DATA_WIDTH-1:0]    ast_data_o          [TX_DIR],
    output logic [TX_DIR-1:0]        ast_startofpacket_o,
    output logic [TX_DIR-1:0]        ast_endofpacket_o,
    output logic [TX_DIR-1:0]        ast_valid_o,
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o         [TX_DIR],
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o       [TX_DIR],
    input  logic [TX_DIR-1:0]        ast_ready_i,
    output logic                     dbg_state_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [DIR_SEL_WIDTH-1:0] r_dir_q;
    logic [DIR_SEL_WIDTH-1:0] w_sel;
    logic [31:0]              w_dir_ext;
    logic                     w_dir_bad;
    logic                     w_drop;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_sop_idle;

    logic [TX_DIR-1:0]        r_valid;
    logic [TX_DIR-1:0]        r_sop;
    logic [TX_DIR-1:0]        r_eop;
    logic [DATA_WIDTH-1:0]    r_data    [TX_DIR];
    logic [EMPTY_WIDTH-1:0]   r_empty   [TX_DIR];
    logic [CHANNEL_WIDTH-1:0] r_channel [TX_DIR];

`ifdef AST_DMX_DROP_BAD_DIR_EN
    logic r_drop;
    logic w_drop_next;
`endif

    // Widened so the range test is a plain 32-bit compare for any TX_DIR.
    assign w_dir_ext = 32'(dir_i);
    assign w_dir_bad = (w_dir_ext >= 32'(TX_DIR));

    // A packet only starts from IDLE; a sop seen mid-packet is carried as data.
    assign w_sop_idle = (r_state == S_IDLE) && ast_startofpacket_i;

    always_comb begin
        w_sel        = r_dir_q;
        w_drop       = 1'b0;
        w_state_next = r_state;
`ifdef AST_DMX_DROP_BAD_DIR_EN
        w_drop_next  = r_drop;
`endif
        if (r_state == S_IDLE) begin
            // Between packets dir_i steers combinationally, so a packet can
            // follow the previous eop with no gap. Out-of-range maps to 0.
            w_sel = w_dir_bad ? '0 : dir_i;
`ifdef AST_DMX_DROP_BAD_DIR_EN
            w_drop = !ast_startofpacket_i || w_dir_bad;
`else
            // A beat with no sop outside a packet has no destination.
            w_drop = !ast_startofpacket_i;
`endif
        end else begin
`ifdef AST_DMX_DROP_BAD_DIR_EN
            w_drop = r_drop;
`endif
        end

        ast_ready_o = w_drop || !r_valid[w_sel] || ast_ready_i[w_sel];
        w_accept    = ast_valid_i && ast_ready_o;
        w_load      = w_accept && !w_drop;

        if (w_accept) begin
            if (w_sop_idle && !ast_endofpacket_i) begin
                w_state_next = S_BUSY;
`ifdef AST_DMX_DROP_BAD_DIR_EN
                w_drop_next  = w_dir_bad;
`endif
            end else if (ast_endofpacket_i) begin
                w_state_next = S_IDLE;
`ifdef AST_DMX_DROP_BAD_DIR_EN
                w_drop_next  = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= S_IDLE;
            r_dir_q <= '0;
`ifdef AST_DMX_DROP_BAD_DIR_EN
            r_drop  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
`ifdef AST_DMX_DROP_BAD_DIR_EN
            r_drop  <= w_drop_next;
`endif
            if (w_accept && w_sop_idle) begin
                r_dir_q <= w_sel;
            end
        end
    end

    // One register per direction: load when selected, else empty on consume.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_valid <= '0;
            r_sop   <= '0;
            r_eop   <= '0;
            for (int k = 0; k < TX_DIR; k++) begin
                r_data[k]    <= '0;
                r_empty[k]   <= '0;
                r_channel[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TX_DIR; k++) begin
                if (w_load && (w_sel == DIR_SEL_WIDTH'(k))) begin
                    r_valid[k]   <= 1'b1;
                    r_sop[k]     <= ast_startofpacket_i;
                    r_eop[k]     <= ast_endofpacket_i;
                    r_data[k]    <= ast_data_i;
                    r_empty[k]   <= ast_empty_i;
                    r_channel[k] <= ast_channel_i;
                end else if (ast_ready_i[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign ast_valid_o         = r_valid;
    assign ast_startofpacket_o = r_sop;
    assign ast_endofpacket_o   = r_eop;
    assign ast_data_o          = r_data;
    assign ast_empty_o         = r_empty;
    assign ast_channel_o       = r_channel;
    assign dbg_state_o         = r_state;

endmodule

// File: tb/tb_ast_dmx.sv
// ---------------------------------------------------------------------------
// tb_ast_dmx : directed and randomised checks for ast_dmx (default parameters).
// Inputs change 1 ns after the rising edge; registered outputs are sampled
// there too, combinational ready 1 ns later, scoreboard on the falling edge.
// ---------------------------------------------------------------------------
module tb_ast_dmx;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int EW = 3;
    localparam int TD = 4;
    localparam int SW = 2;
    localparam int BW = 2 + EW + CW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic srst_i;
    always #5 clk = ~clk;

    logic [SW-1:0] dir_i;
    logic [DW-1:0] ast_data_i;
    logic          ast_startofpacket_i;
    logic          ast_endofpacket_i;
    logic          ast_valid_i;
    logic [EW-1:0] ast_empty_i;
    logic [CW-1:0] ast_channel_i;
    logic          ast_ready_o;
    logic [DW-1:0] ast_data_o [TD];
    logic [TD-1:0] ast_startofpacket_o;
    logic [TD-1:0] ast_endofpacket_o;
    logic [TD-1:0] ast_valid_o;
    logic [EW-1:0] ast_empty_o [TD];
    logic [CW-1:0] ast_channel_o [TD];
    logic [TD-1:0] ast_ready_i;
    logic          dbg_state_o;

    ast_dmx dut (
        .clk_i               (clk),
        .srst_i              (srst_i),
        .dir_i               (dir_i),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i),
        .dbg_state_o         (dbg_state_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q [TD][$];
    logic          sb_en = 1'b0;

    function automatic logic [BW-1:0] bt(input logic s, input logic e, input logic [EW-1:0] emp,
                                         input logic [CW-1:0] ch, input logic [DW-1:0] d);
        return {s, e, emp, ch, d};
    endfunction

    function automatic logic [BW-1:0] obs(input int k);
        return {ast_startofpacket_o[k], ast_endofpacket_o[k], ast_empty_o[k], ast_channel_o[k], ast_data_o[k]};
    endfunction

    always @(negedge clk) begin
        if (sb_en) begin
            for (int k = 0; k < TD; k++) begin
                if (ast_valid_o[k] && ast_ready_i[k]) begin
                    logic [BW-1:0] e;
                    n_vec++;
                    if (exp_q[k].size() == 0) begin
                        n_err++;
                        $display("FAIL sb_extra dir%0d: got %h, expected no beat", k, obs(k));
                    end else begin
                        e = exp_q[k].pop_front();
                        if (obs(k) !== e) begin
                            n_err++;
                            $display("FAIL sb_beat dir%0d: got %h, expected %h", k, obs(k), e);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [SW-1:0] d,
                         input logic [DW-1:0] dat, input logic [EW-1:0] emp, input logic [CW-1:0] ch);
        ast_valid_i         = v;
        ast_startofpacket_i = s;
        ast_endofpacket_i   = e;
        dir_i               = d;
        ast_data_i          = dat;
        ast_empty_i         = emp;
        ast_channel_i       = ch;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        srst_i      = 1'b1;
        ast_ready_i = '1;
        drive(0, 0, 0, 0, '0, '0, '0);
        step();
        step();
        srst_i = 1'b0;
        n_vec++;
        if (ast_valid_o !== 4'b0000) begin
            n_err++; $display("FAIL rst_valid: got %b, expected 0000", ast_valid_o);
        end
        for (int k = 0; k < TD; k++) begin
            n_vec++;
            if (obs(k) !== '0) begin
                n_err++; $display("FAIL rst_regs dir%0d: got %h, expected 0", k, obs(k));
            end
        end
        #1;
        n_vec++;
        if ({ast_ready_o, dbg_state_o} !== 2'b10) begin
            n_err++; $display("FAIL rst_ready_state: got %b, expected 10", {ast_ready_o, dbg_state_o});
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] d [3];
        d[0] = 64'h11; d[1] = 64'h22; d[2] = 64'h33;
        ast_ready_i = '1;
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, i == 2, 2, d[i], (i == 2) ? 3'd5 : 3'd0, 8'h07);
            #1;
            n_vec++;
            if (ast_ready_o !== 1'b1) begin
                n_err++; $display("FAIL single_ready beat%0d: got %b, expected 1", i, ast_ready_o);
            end
            step();
            n_vec++;
            if (ast_valid_o !== 4'b0100) begin
                n_err++; $display("FAIL single_valid beat%0d: got %b, expected 0100", i, ast_valid_o);
            end
            n_vec++;
            if (obs(2) !== bt(i == 0, i == 2, (i == 2) ? 3'd5 : 3'd0, 8'h07, d[i])) begin
                n_err++; $display("FAIL single_beat beat%0d: got %h, expected %h", i, obs(2),
                                  bt(i == 0, i == 2, (i == 2) ? 3'd5 : 3'd0, 8'h07, d[i]));
            end
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        step();
        n_vec++;
        if (ast_valid_o !== 4'b0000) begin
            n_err++; $display("FAIL single_drain: got %b, expected 0000", ast_valid_o);
        end
    endtask

    task automatic test_dir_change();
        ast_ready_i = '1;
        for (int i = 0; i < 4; i++) begin
            drive(1, i == 0, i == 3, (i == 0) ? 2'd1 : 2'd3, 64'hA0 + 64'(i), (i == 3) ? 3'd2 : 3'd0, 8'h12);
            step();
            n_vec++;
            if (ast_valid_o !== 4'b0010) begin
                n_err++; $display("FAIL dirchg_valid beat%0d: got %b, expected 0010", i, ast_valid_o);
            end
            n_vec++;
            if (obs(1) !== bt(i == 0, i == 3, (i == 3) ? 3'd2 : 3'd0, 8'h12, 64'hA0 + 64'(i))) begin
                n_err++; $display("FAIL dirchg_beat beat%0d: got %h, expected %h", i, obs(1),
                                  bt(i == 0, i == 3, (i == 3) ? 3'd2 : 3'd0, 8'h12, 64'hA0 + 64'(i)));
            end
            if (i == 0) begin
                n_vec++;
                if (dbg_state_o !== 1'b1) begin
                    n_err++; $display("FAIL dirchg_busy: got %b, expected 1", dbg_state_o);
                end
            end
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        step();
        n_vec++;
        if ({ast_valid_o, dbg_state_o} !== 5'b00000) begin
            n_err++; $display("FAIL dirchg_end: got %b, expected 00000", {ast_valid_o, dbg_state_o});
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] got[$];
        int            bi;
        logic          acc;
        bi = 0;
        ast_ready_i = '1;
        for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
            ast_ready_i[0] = (cyc >= 5);
            if (bi < 4) drive(1, bi == 0, bi == 3, 0, 64'hB0 + 64'(bi), 3'(bi), 8'h40);
            else        drive(0, 0, 0, 0, '0, '0, '0);
            #1;
            if (cyc == 0 || cyc == 1 || cyc == 4) begin
                n_vec++;
                if (ast_ready_o !== (cyc == 0)) begin
                    n_err++; $display("FAIL bp_ready cyc%0d: got %b, expected %b", cyc, ast_ready_o, cyc == 0);
                end
            end
            if (ast_valid_o[0] && ast_ready_i[0]) got.push_back(obs(0));
            acc = ast_valid_i && ast_ready_o;
            step();
            if (acc) bi++;
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        ast_ready_i = '1;
        step();
        n_vec++;
        if (got.size() != 4) begin
            n_err++; $display("FAIL bp_count: got %0d beats, expected 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== bt(i == 0, i == 3, 3'(i), 8'h40, 64'hB0 + 64'(i))) begin
                n_err++; $display("FAIL bp_order beat%0d: got %h, expected %h", i, got[i],
                                  bt(i == 0, i == 3, 3'(i), 8'h40, 64'hB0 + 64'(i)));
            end
        end
    endtask

    task automatic test_back_to_back();
        ast_ready_i = '1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 2'(i), 64'hC0 + 64'(i), 3'(i), 8'h30 + 8'(i));
            #1;
            n_vec++;
            if (ast_ready_o !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready pkt%0d: got %b, expected 1", i, ast_ready_o);
            end
            step();
            n_vec++;
            if (ast_valid_o !== 4'(1 << i)) begin
                n_err++; $display("FAIL b2b_valid pkt%0d: got %b, expected %b", i, ast_valid_o, 4'(1 << i));
            end
            n_vec++;
            if (obs(i) !== bt(1, 1, 3'(i), 8'h30 + 8'(i), 64'hC0 + 64'(i))) begin
                n_err++; $display("FAIL b2b_beat pkt%0d: got %h, expected %h", i, obs(i),
                                  bt(1, 1, 3'(i), 8'h30 + 8'(i), 64'hC0 + 64'(i)));
            end
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        step();
        n_vec++;
        if (ast_valid_o !== 4'b0000) begin
            n_err++; $display("FAIL b2b_drain: got %b, expected 0000", ast_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        ast_ready_i = '1;
        drive(1, 1, 0, 2, 64'h51, 0, 8'h09);
        step();
        drive(1, 0, 0, 2, 64'h52, 0, 8'h09);
        step();
        srst_i = 1'b1;
        drive(0, 0, 0, 0, '0, '0, '0);
        step();
        srst_i = 1'b0;
        n_vec++;
        if ({ast_valid_o, dbg_state_o} !== 5'b00000) begin
            n_err++; $display("FAIL rstmid_clear: got %b, expected 00000", {ast_valid_o, dbg_state_o});
        end
        // Continuation beat without sop after reset: swallowed.
        drive(1, 0, 0, 2, 64'h53, 0, 8'h09);
        #1;
        n_vec++;
        if (ast_ready_o !== 1'b1) begin
            n_err++; $display("FAIL orphan_ready: got %b, expected 1", ast_ready_o);
        end
        step();
        n_vec++;
        if (ast_valid_o !== 4'b0000) begin
            n_err++; $display("FAIL orphan_drop: got %b, expected 0000", ast_valid_o);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, i == 0, i == 1, 1, 64'hD0 + 64'(i), (i == 1) ? 3'd4 : 3'd0, 8'h55);
            step();
            n_vec++;
            if ({ast_valid_o, obs(1)} !== {4'b0010, bt(i == 0, i == 1, (i == 1) ? 3'd4 : 3'd0, 8'h55, 64'hD0 + 64'(i))}) begin
                n_err++; $display("FAIL rstmid_new beat%0d: got %b/%h, expected 0010/%h", i, ast_valid_o, obs(1),
                                  bt(i == 0, i == 1, (i == 1) ? 3'd4 : 3'd0, 8'h55, 64'hD0 + 64'(i)));
            end
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        step();
    endtask

    task automatic test_random();
        logic          abort;
        int            len;
        logic [SW-1:0] dir;
        logic [CW-1:0] ch;
        logic [DW-1:0] dat;
        logic [EW-1:0] emp;
        int            waited;
        abort = 1'b0;
        sb_en = 1'b1;
        for (int p = 0; p < 1000 && !abort; p++) begin
            len = $urandom_range(1, 5);
            dir = 2'($urandom_range(0, 3));
            ch  = 8'($urandom);
            for (int b = 0; b < len && !abort; b++) begin
                if ($urandom_range(0, 7) == 0) begin
                    ast_valid_i = 1'b0;
                    ast_ready_i = 4'($urandom);
                    step();
                end
                dat = {$urandom, $urandom};
                emp = 3'($urandom);
                // dir_i wanders on non-sop beats; it must be ignored there.
                drive(1, b == 0, b == len - 1, (b == 0) ? dir : 2'($urandom_range(0, 3)), dat, emp, ch);
                waited = 0;
                forever begin
                    ast_ready_i = 4'($urandom);
                    #1;
                    if (ast_ready_o) begin
                        exp_q[dir].push_back(bt(b == 0, b == len - 1, emp, ch, dat));
                        step();
                        break;
                    end
                    step();
                    waited++;
                    if (waited > 50) begin
                        n_vec++; n_err++;
                        $display("FAIL rand_timeout pkt%0d beat%0d: ready_o low for %0d cycles, expected <=50", p, b, waited);
                        abort = 1'b1;
                        break;
                    end
                end
            end
        end
        drive(0, 0, 0, 0, '0, '0, '0);
        ast_ready_i = '1;
        repeat (4) step();
        sb_en = 1'b0;
        for (int k = 0; k < TD; k++) begin
            n_vec++;
            if (exp_q[k].size() != 0) begin
                n_err++; $display("FAIL rand_missing dir%0d: got %0d undelivered beats, expected 0", k, exp_q[k].size());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_dir_change();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
